id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_skid_buf.sv | 81 ++++++++
 rtl/id_ex_stage.sv | 96 +++++++++
 tb/tb_id_ex_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline definitions (control-bundle layout, forwarding codes, buffer states).
// Revision: 1.0
`default_nettype none

package pipe_pkg;

   localparam int CTRL_W = 8;

   localparam int CTRL_BRANCH     = 7;
   localparam int CTRL_MEM_READ   = 6;
   localparam int CTRL_MEM_TO_REG = 5;
   localparam int CTRL_ALU_OP_HI  = 4;
   localparam int CTRL_ALU_OP_LO  = 3;
   localparam int CTRL_MEM_WRITE  = 2;
   localparam int CTRL_ALU_SRC    = 1;
   localparam int CTRL_REG_WRITE  = 0;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry (main + skid) pipeline buffer with registered in_ready.
// Revision: 1.0
`default_nettype none

module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CLR_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   skid_state_t      state, state_nx;
   logic             ready_q;
   logic [WIDTH-1:0] main_q, skid_q;
   logic             accept, release_e;

   assign accept    = in_valid && ready_q;
   assign release_e = out_valid && out_ready;
   assign in_ready  = ready_q;
   assign out_valid = (state != ST_EMPTY);
   assign out_data  = main_q;

   always_comb begin
      state_nx = state;
      case (state)
         ST_EMPTY: if (accept) state_nx = ST_BUSY;
         ST_BUSY: begin
            if (accept && !release_e)      state_nx = ST_FULL;
            else if (!accept && release_e) state_nx = ST_EMPTY;
         end
         ST_FULL:  if (release_e) state_nx = ST_BUSY;
         default:  state_nx = ST_EMPTY;
      endcase
      if (flush) state_nx = ST_EMPTY;
   end

   // in_ready is registered from the next state so out_ready never reaches it combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state   <= state_nx;
         ready_q <= (state_nx != ST_FULL);
      end
   end

   // Flush clears only the control slice; data fields keep their last values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         main_q[CLR_W-1:0] <= '0;
         skid_q[CLR_W-1:0] <= '0;
      end else begin
         case (state)
            ST_EMPTY: if (accept) main_q <= in_data;
            ST_BUSY: begin
               if (accept && release_e) main_q <= in_data;
               else if (accept)         skid_q <= in_data;
            end
            ST_FULL:  if (release_e) main_q <= skid_q;
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register built on a skid buffer, with optional forwarding
// detection enabled by macro ID_EX_FWD_DETECT_EN.  Revision: 1.0
`default_nettype none

module id_ex_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CTRL_W     = pipe_pkg::CTRL_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  flush,
   input  logic                  nop,
   input  logic [CTRL_W-1:0]     ctrl,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [XLEN-1:0]       rdata1,
   input  logic [XLEN-1:0]       rdata2,
   input  logic [XLEN-1:0]       imm,
   input  logic [XLEN-1:0]       pc,
   input  logic [6:0]            opcode,
   input  logic [3:0]            alu_op,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic [REG_ADDR_W-1:0] ex_rs1,
   output logic [REG_ADDR_W-1:0] ex_rs2,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [XLEN-1:0]       ex_rdata1,
   output logic [XLEN-1:0]       ex_rdata2,
   output logic [XLEN-1:0]       ex_imm,
   output logic [XLEN-1:0]       ex_pc,
   output logic [6:0]            ex_opcode,
   output logic [3:0]            ex_alu_op,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  mem_regwrite,
   input  logic                  wb_regwrite,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b
);

   import pipe_pkg::*;

   localparam int PAY_W = CTRL_W + 3*REG_ADDR_W + 4*XLEN + 7 + 4;

   logic [PAY_W-1:0]  pay_in, pay_out;
   logic [CTRL_W-1:0] ctrl_in, main_ctrl;

   assign ctrl_in = nop ? {CTRL_W{1'b0}} : ctrl;
   // Control bundle sits in the low bits so the buffer can clear it on flush.
   assign pay_in  = {alu_op, opcode, pc, imm, rdata2, rdata1, rd, rs2, rs1, ctrl_in};

   pipe_skid_buf #(
      .WIDTH (PAY_W),
      .CLR_W (CTRL_W)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (pay_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (pay_out)
   );

   assign {ex_alu_op, ex_opcode, ex_pc, ex_imm, ex_rdata2, ex_rdata1,
           ex_rd, ex_rs2, ex_rs1, main_ctrl} = pay_out;
   assign ex_ctrl = out_valid ? main_ctrl : {CTRL_W{1'b0}};

`ifdef ID_EX_FWD_DETECT_EN
   always_comb begin
      fwd_a = FWD_NONE;
      fwd_b = FWD_NONE;
      if (out_valid) begin
         if (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs1)   fwd_a = FWD_MEM;
         else if (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs1) fwd_a = FWD_WB;
         if (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs2)   fwd_b = FWD_MEM;
         else if (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs2) fwd_b = FWD_WB;
      end
   end
`else
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{mem_rd, wb_rd, mem_regwrite, wb_regwrite};
   assign fwd_a = FWD_NONE;
   assign fwd_b = FWD_NONE;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage.
// Revision: 1.0
`default_nettype none

module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, flush, nop;
   logic [7:0]  ctrl, ex_ctrl;
   logic [4:0]  rs1, rs2, rd, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic [31:0] rdata1, rdata2, imm, pc, ex_rdata1, ex_rdata2, ex_imm, ex_pc;
   logic [6:0]  opcode, ex_opcode;
   logic [3:0]  alu_op, ex_alu_op;
   logic        mem_regwrite, wb_regwrite;
   logic [1:0]  fwd_a, fwd_b;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .nop(nop),
      .ctrl(ctrl), .rs1(rs1), .rs2(rs2), .rd(rd), .rdata1(rdata1), .rdata2(rdata2),
      .imm(imm), .pc(pc), .opcode(opcode), .alu_op(alu_op),
      .ex_ctrl(ex_ctrl), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc(ex_pc),
      .ex_opcode(ex_opcode), .ex_alu_op(ex_alu_op),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite),
      .wb_regwrite(wb_regwrite), .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   typedef struct packed {
      logic [7:0]  ctrl;
      logic [31:0] rdata1;
      logic [31:0] pc;
      logic [4:0]  rs1;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every completed EX-side handshake is matched against the next expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_release", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rel_ctrl",   {56'd0, ex_ctrl},   {56'd0, e.ctrl});
               chk("rel_rdata1", {32'd0, ex_rdata1}, {32'd0, e.rdata1});
               chk("rel_pc",     {32'd0, ex_pc},     {32'd0, e.pc});
               chk("rel_rs1",    {59'd0, ex_rs1},    {59'd0, e.rs1});
            end
         end
      end
   end

   // Presents one entry and waits (bounded) for it to be accepted; caller is at posedge+1.
   task automatic send(input logic [7:0] c, input logic [31:0] d1, input logic [31:0] p,
                       input logic [4:0] r1, input logic n);
      bit ok = 0;
      exp_t e;
      in_valid = 1'b1; ctrl = c; rdata1 = d1; pc = p; rs1 = r1; nop = n;
      rs2 = 5'd7; rd = 5'd3; rdata2 = 32'h2222; imm = 32'h10; opcode = 7'h33; alu_op = 4'h2;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.ctrl = n ? 8'h00 : c; e.rdata1 = d1; e.pc = p; e.rs1 = r1;
            exp_q.push_back(e);
            ok = 1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0; nop = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 0; out_ready = 0; flush = 0; nop = 0;
      ctrl = 0; rs1 = 0; rs2 = 0; rd = 0; rdata1 = 0; rdata2 = 0; imm = 0; pc = 0;
      opcode = 0; alu_op = 0; mem_rd = 0; wb_rd = 0; mem_regwrite = 0; wb_regwrite = 0;
      cycles(3);
      rst = 1'b0;
      cycles(1);

      chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_ex_ctrl",   {56'd0, ex_ctrl},   64'd0);
      chk("reset_fwd_a",     {62'd0, fwd_a},     64'd0);

      // Single-cycle latency from accept to out_valid.
      out_ready = 1'b1;
      send(8'h83, 32'hA0A0_0001, 32'h0000_1000, 5'd1, 1'b0);
      chk("lat_out_valid", {63'd0, out_valid}, 64'd1);
      chk("lat_ex_ctrl",   {56'd0, ex_ctrl},   64'h83);
      cycles(2);

      // Backpressure: fill main and skid, then check a third entry is refused.
      out_ready = 1'b0;
      send(8'h11, 32'hB000_000A, 32'h0000_2000, 5'd2, 1'b0);
      send(8'h22, 32'hB000_000B, 32'h0000_2004, 5'd3, 1'b0);
      chk("full_in_ready", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b1; ctrl = 8'h33; rdata1 = 32'hDEAD_0000;
      cycles(3);
      chk("full_still_blocked", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      cycles(4);
      chk("drained_out_valid", {63'd0, out_valid}, 64'd0);
      chk("drained_in_ready",  {63'd0, in_ready},  64'd1);
      chk("drained_ex_ctrl",   {56'd0, ex_ctrl},   64'd0);

      // Bubble: control zeroed, data kept.
      send(8'hFF, 32'h5555_AAAA, 32'h0000_3000, 5'd4, 1'b1);
      cycles(2);

      // Flush while FULL with a simultaneous accept attempt.
      out_ready = 1'b0;
      send(8'h44, 32'hC000_0001, 32'h0000_4000, 5'd5, 1'b0);
      send(8'h55, 32'hC000_0002, 32'h0000_4004, 5'd6, 1'b0);
      in_valid = 1'b1; ctrl = 8'h66; rdata1 = 32'hC000_0003; flush = 1'b1;
      cycles(1);
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_ex_ctrl",   {56'd0, ex_ctrl},   64'd0);
      chk("flush_in_ready",  {63'd0, in_ready},  64'd1);
      out_ready = 1'b1;
      cycles(3);
      chk("flush_no_entry", {63'd0, out_valid}, 64'd0);

      // Forwarding detection on a held entry with ex_rs1=5, ex_rs2=7.
      out_ready = 1'b0;
      send(8'h01, 32'hF000_0001, 32'h0000_5000, 5'd5, 1'b0);
      mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1;
      #2;
`ifdef ID_EX_FWD_DETECT_EN
      chk("fwd_a_mem", {62'd0, fwd_a}, 64'd2);
`else
      chk("fwd_a_off", {62'd0, fwd_a}, 64'd0);
`endif
      chk("fwd_b_none", {62'd0, fwd_b}, 64'd0);
      mem_rd = 5'd0;
      #2;
`ifdef ID_EX_FWD_DETECT_EN
      chk("fwd_a_wb", {62'd0, fwd_a}, 64'd1);
`else
      chk("fwd_a_off2", {62'd0, fwd_a}, 64'd0);
`endif
      wb_rd = 5'd7;
      #2;
`ifdef ID_EX_FWD_DETECT_EN
      chk("fwd_b_wb", {62'd0, fwd_b}, 64'd1);
`else
      chk("fwd_b_off", {62'd0, fwd_b}, 64'd0);
`endif
      mem_regwrite = 1'b0; wb_regwrite = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      cycles(2);
      out_ready = 1'b0;

      // Asynchronous reset mid-transfer while FULL.
      send(8'h77, 32'hE000_0001, 32'h0000_6000, 5'd8, 1'b0);
      send(8'h78, 32'hE000_0002, 32'h0000_6004, 5'd9, 1'b0);
      in_valid = 1'b1;
      #3;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
      chk("rst_ex_ctrl",   {56'd0, ex_ctrl},   64'd0);
      chk("rst_ex_rdata1", {32'd0, ex_rdata1}, 64'd0);
      chk("rst_ex_pc",     {32'd0, ex_pc},     64'd0);
      in_valid = 1'b0;
      cycles(2);
      rst = 1'b0;
      cycles(2);

      chk("queue_empty", {32'd0, exp_q.size()}, 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
